throw_power_ctrl: RTL and testbench

THROW_POWER_CTRL -- requirements
Module: throw_power_ctrl

---
 rtl/throw_power_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_throw_power_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/throw_power_ctrl.sv
// throw_power_ctrl
// Space-bar throw power meter. A debounced press in IDLE starts a charge;
// while the key stays held the meter ping-pongs between 0 and 255 in STEP
// increments once per frame. Releasing fires a throw request with the
// latched power (or aborts if below MIN_POWER), then the block waits for
// the game to report throw completion, or gives up after a frame timeout.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   key_space   in   space key level (clk-synchronous)
//   frame_tick  in   one-cycle pulse per frame
//   throw_ready in   game controller accepts a request
//   throw_done  in   one-cycle pulse when the throw completes
//   throw_req   out  throw request valid
//   throw_power out  latched power, stable while throw_req=1
//   power_bar   out  live meter value
//   charging    out  high in CHARGE
//   busy        out  high in FIRE or WAIT_DONE
module throw_power_ctrl #(
    parameter int STEP            = 4,
    parameter int MIN_POWER       = 16,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int TIMEOUT_FRAMES  = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_space,
    input  logic       frame_tick,
    input  logic       throw_ready,
    input  logic       throw_done,
    output logic       throw_req,
    output logic [7:0] throw_power,
    output logic [7:0] power_bar,
    output logic       charging,
    output logic       busy
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CHARGE    = 2'd1;
    localparam logic [1:0] FIRE      = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam int DW = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);
    localparam int TW = (TIMEOUT_FRAMES  < 2) ? 1 : $clog2(TIMEOUT_FRAMES + 1);

    logic [1:0]    state_q, state_d;
    logic          throw_req_q, throw_req_d;
    logic [7:0]    throw_power_q, throw_power_d;
    logic [7:0]    power_bar_q, power_bar_d;
    logic          dir_up_q, dir_up_d;
    logic          armed_q, armed_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic [DW-1:0] deb_inc;
    logic [TW-1:0] to_inc;
    logic [8:0]    up_sum;

    assign deb_inc = deb_cnt_q + DW'(1);
    assign to_inc  = to_cnt_q + TW'(1);
    // 9-bit so an overshoot past 255 is visible before saturating
    assign up_sum  = {1'b0, power_bar_q} + 9'(STEP);

    always_comb begin
        state_d       = state_q;
        throw_req_d   = throw_req_q;
        throw_power_d = throw_power_q;
        power_bar_d   = power_bar_q;
        dir_up_d      = dir_up_q;
        armed_d       = armed_q;
        deb_cnt_d     = deb_cnt_q;
        to_cnt_d      = to_cnt_q;

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (!key_space) begin
                        // any low sample re-arms and restarts the debounce run
                        armed_d   = 1'b1;
                        deb_cnt_d = '0;
                    end else if (armed_q) begin
                        if (deb_inc == DW'(DEBOUNCE_FRAMES)) begin
                            state_d     = CHARGE;
                            power_bar_d = 8'd0;
                            dir_up_d    = 1'b1;
                            armed_d     = 1'b0;
                            deb_cnt_d   = '0;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
            end
            CHARGE: begin
                if (frame_tick) begin
                    if (key_space) begin
                        if (dir_up_q) begin
                            if (up_sum > 9'd255) begin
                                power_bar_d = 8'd255;
                                dir_up_d    = 1'b0;
                            end else begin
                                power_bar_d = up_sum[7:0];
                            end
                        end else begin
                            if (power_bar_q < 8'(STEP)) begin
                                power_bar_d = 8'd0;
                                dir_up_d    = 1'b1;
                            end else begin
                                power_bar_d = power_bar_q - 8'(STEP);
                            end
                        end
                    end else if (power_bar_q < 8'(MIN_POWER)) begin
                        state_d     = IDLE;
                        power_bar_d = 8'd0;
                    end else begin
                        throw_power_d = power_bar_q;
                        throw_req_d   = 1'b1;
                        state_d       = FIRE;
                    end
                end
            end
            FIRE: begin
                // handshake is cycle-accurate, independent of frame_tick
                if (throw_req_q && throw_ready) begin
                    throw_req_d = 1'b0;
                    to_cnt_d    = '0;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // done takes priority over a coincident timeout
                if (throw_done) begin
                    state_d     = IDLE;
                    power_bar_d = 8'd0;
                    to_cnt_d    = '0;
                end else if (frame_tick) begin
                    if (to_inc == TW'(TIMEOUT_FRAMES)) begin
                        state_d     = IDLE;
                        power_bar_d = 8'd0;
                        to_cnt_d    = '0;
                    end else begin
                        to_cnt_d = to_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            throw_req_q   <= 1'b0;
            throw_power_q <= 8'd0;
            power_bar_q   <= 8'd0;
            dir_up_q      <= 1'b1;
            armed_q       <= 1'b0;
            deb_cnt_q     <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            throw_req_q   <= throw_req_d;
            throw_power_q <= throw_power_d;
            power_bar_q   <= power_bar_d;
            dir_up_q      <= dir_up_d;
            armed_q       <= armed_d;
            deb_cnt_q     <= deb_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign throw_req   = throw_req_q;
    assign throw_power = throw_power_q;
    assign power_bar   = power_bar_q;
    assign charging    = (state_q == CHARGE);
    assign busy        = (state_q == FIRE) || (state_q == WAIT_DONE);

endmodule

// File: tb/tb_throw_power_ctrl.sv
// Bench for throw_power_ctrl: scoreboard of expected throw_power values,
// pushed when a release is driven and popped on each accepted handshake.
module tb_throw_power_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_space, frame_tick, throw_ready, throw_done;
    logic       throw_req;
    logic [7:0] throw_power, power_bar;
    logic       charging, busy;

    int         vectors = 0;
    int         errors  = 0;
    int         req_cycles = 0;
    logic [7:0] sb[$];

    throw_power_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_space  (key_space),
        .frame_tick (frame_tick),
        .throw_ready(throw_ready),
        .throw_done (throw_done),
        .throw_req  (throw_req),
        .throw_power(throw_power),
        .power_bar  (power_bar),
        .charging   (charging),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Handshake monitor: inputs change at negedge, so +1 sees what the next
    // posedge will act on.
    always @(negedge clk) begin
        #1;
        if (rst_n && throw_req) begin
            req_cycles++;
            if (throw_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_req: got power %0d, expected no request", throw_power);
                end else begin
                    logic [7:0] exp_p;
                    exp_p = sb.pop_front();
                    if (throw_power !== exp_p) begin
                        errors++;
                        $display("FAIL sb_power: got %0d, expected %0d", throw_power, exp_p);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    // low sample then two high samples: ends in CHARGE with key held
    task automatic press();
        key_space = 1'b0; tick();
        key_space = 1'b1; tick(); tick();
    endtask

    task automatic chk(input string name, input int got, input int exp_v);
        vectors++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
        end
    endtask

    task automatic done_pulse();
        @(negedge clk); throw_done = 1'b1;
        @(negedge clk); throw_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_space = 1'b0; frame_tick = 1'b0;
        throw_ready = 1'b0; throw_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", int'(throw_req), 0);
        chk("rst_power", int'(throw_power), 0);
        chk("rst_bar", int'(power_bar), 0);
        chk("rst_busy", int'(busy || charging), 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_throw();
        press();
        chk("press_charging", int'(charging), 1);
        chk("press_bar0", int'(power_bar), 0);
        repeat (10) tick();
        chk("throw_bar40", int'(power_bar), 40);
        throw_ready = 1'b1;
        req_cycles = 0;
        sb.push_back(8'd40);
        key_space = 1'b0; tick();
        @(negedge clk); #2;
        chk("throw_req_cycles", req_cycles, 1);
        chk("throw_req_low", int'(throw_req), 0);
        chk("throw_busy", int'(busy), 1);
        chk("throw_bar", int'(power_bar), 40);
        chk("throw_power", int'(throw_power), 40);
        done_pulse();
        chk("throw_done_idle", int'(busy), 0);
        chk("throw_done_bar", int'(power_bar), 0);
    endtask

    task automatic test_saturate();
        int prev;
        press();
        prev = 0;
        for (int t = 1; t <= 70; t++) begin
            tick();
            if (t == 63) chk("sat_t63", int'(power_bar), 252);
            if (t == 64) chk("sat_t64", int'(power_bar), 255);
            if (t == 65) chk("sat_t65", int'(power_bar), 251);
            if (t == 70) chk("sat_t70", int'(power_bar), 231);
            if (t > 64 && int'(power_bar) >= prev) chk("sat_monotone", int'(power_bar), prev - 4);
            prev = int'(power_bar);
        end
        sb.push_back(8'd231);
        key_space = 1'b0; tick();
        @(negedge clk); #2;
        chk("sat_busy", int'(busy), 1);
        done_pulse();
    endtask

    task automatic test_short();
        press();
        repeat (3) tick();
        chk("short_bar12", int'(power_bar), 12);
        req_cycles = 0;
        key_space = 1'b0; tick();
        chk("short_charging", int'(charging), 0);
        chk("short_busy", int'(busy), 0);
        chk("short_bar0", int'(power_bar), 0);
        repeat (2) @(negedge clk);
        chk("short_no_req", req_cycles, 0);
    endtask

    task automatic test_stall();
        press();
        repeat (5) tick();
        throw_ready = 1'b0;
        sb.push_back(8'd20);
        key_space = 1'b0; tick();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            frame_tick = (i % 5 == 0);
            #2;
            chk("stall_req", int'(throw_req), 1);
            chk("stall_power", int'(throw_power), 20);
        end
        @(negedge clk); frame_tick = 1'b0; throw_ready = 1'b1;
        @(negedge clk); #2;
        chk("stall_accept_req", int'(throw_req), 0);
        chk("stall_wait_busy", int'(busy), 1);
        done_pulse();
    endtask

    task automatic test_timeout();
        throw_ready = 1'b1;
        press();
        repeat (5) tick();
        sb.push_back(8'd20);
        key_space = 1'b0; tick();
        @(negedge clk);
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (i == 599) chk("to_busy_599", int'(busy), 1);
            if (i == 600) begin
                chk("to_idle_600", int'(busy), 0);
                chk("to_bar0", int'(power_bar), 0);
            end
        end
    endtask

    task automatic test_done_key();
        press();
        repeat (5) tick();
        sb.push_back(8'd20);
        key_space = 1'b0; tick();
        @(negedge clk);
        key_space = 1'b1;
        tick();
        done_pulse();
        chk("dk_idle", int'(busy), 0);
        repeat (3) tick();
        chk("dk_held_no_charge", int'(charging), 0);
        key_space = 1'b0; tick();
        key_space = 1'b1; tick();
        chk("dk_one_high", int'(charging), 0);
        tick();
        chk("dk_two_high", int'(charging), 1);
        key_space = 1'b0; tick();
        chk("dk_abort", int'(charging), 0);
    endtask

    task automatic test_async_reset();
        // mid-CHARGE
        press();
        repeat (6) tick();
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        chk("ar_charge_bar", int'(power_bar), 0);
        chk("ar_charge_charging", int'(charging), 0);
        @(negedge clk); rst_n = 1'b1;
        // mid-FIRE, held off by throw_ready=0
        throw_ready = 1'b0;
        press();
        repeat (6) tick();
        key_space = 1'b0; tick();
        @(negedge clk); #2;
        chk("ar_fire_req_before", int'(throw_req), 1);
        rst_n = 1'b0; #1;
        chk("ar_fire_req", int'(throw_req), 0);
        chk("ar_fire_power", int'(throw_power), 0);
        chk("ar_fire_busy", int'(busy), 0);
        chk("ar_fire_bar", int'(power_bar), 0);
        // key held through reset must be released before charging
        key_space = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) tick();
        chk("ar_held_no_charge", int'(charging), 0);
        key_space = 1'b0; tick();
        key_space = 1'b1; tick(); tick();
        chk("ar_rearmed_charge", int'(charging), 1);
        key_space = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_throw();
        test_saturate();
        test_short();
        test_stall();
        test_timeout();
        test_done_key();
        test_async_reset();
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
